// File: rtl/mem_bus_arbiter.sv
// Purpose: share one req/ack memory bus between the IF fetch port and the MEM data port, with a stall-cycle counter.
// Latency: bus request one cycle after the grant, port ack one cycle after mem_ack_i, next arbitration one cycle later.
// Backpressure: ports hold req until their ack; stall_o stays high and the bus registers hold while memory has not acked.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_t;

    state_t            state_q, state_d;
    logic              last_d_q;
    bus_t              bus_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              grant_i;
    logic              grant_d;
    logic              rd_done;

    // On a tie, last_d_q selects the port that was not served last time.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = d_req_i & (~if_req_i | ~last_d_q);
                grant_i = if_req_i & (~d_req_i | last_d_q);
                if (grant_d)      state_d = BUS_D;
                else if (grant_i) state_d = BUS_I;
            end
            BUS_I, BUS_D: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                    rd_done = ~bus_q.we;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            bus_q     <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                last_d_q    <= 1'b1;
                bus_q.we    <= d_we_i;
                bus_q.addr  <= d_addr_i;
                bus_q.wdata <= d_wdata_i;
            end else if (grant_i) begin
                last_d_q    <= 1'b0;
                bus_q.we    <= 1'b0;
                bus_q.addr  <= if_addr_i;
                bus_q.wdata <= '0;
            end
            if (rd_done && state_q == BUS_I) if_data_q <= mem_rdata_i;
            if (rd_done && state_q == BUS_D) d_rdata_q <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                     cnt_q <= '0;
        else if (stall_o && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end

    // In RESP the owner is always the most recent grant.
    assign if_ack_o    = (state_q == RESP) & ~last_d_q;
    assign d_ack_o     = (state_q == RESP) &  last_d_q;
    assign mem_req_o   = (state_q == BUS_I) | (state_q == BUS_D);
    assign mem_we_o    = bus_q.we;
    assign mem_addr_o  = bus_q.addr;
    assign mem_wdata_o = bus_q.wdata;
    assign if_data_o   = if_data_q;
    assign d_rdata_o   = d_rdata_q;
    assign stall_cnt_o = cnt_q;
    // Gated by reset so every output reads 0 while reset is held.
    assign stall_o     = rst_i & ((if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; memory responses are driven by hand, counter width 4.
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic [3:0]  stall_cnt_o;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_req"},  {31'b0, mem_req_o}, 32'd0);
        check({tag, "_mem_we"},   {31'b0, mem_we_o}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_mem_wdat"}, mem_wdata_o, 32'd0);
        check({tag, "_if_ack"},   {31'b0, if_ack_o}, 32'd0);
        check({tag, "_d_ack"},    {31'b0, d_ack_o}, 32'd0);
        check({tag, "_if_data"},  if_data_o, 32'd0);
        check({tag, "_d_rdata"},  d_rdata_o, 32'd0);
        check({tag, "_stall"},    {31'b0, stall_o}, 32'd0);
        check({tag, "_cnt"},      {28'b0, stall_cnt_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
        d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        #1;
        check_zero_outputs("rst0");
        tick(); tick();
        rst_i = 1'b1;
        tick();
        check_zero_outputs("idle0");

        // IF read, memory acks three cycles after mem_req_o rises
        if_req_i = 1'b1; if_addr_i = 32'h4;
        #1;
        check("ifrd_stall_pre", {31'b0, stall_o}, 32'd1);
        check("ifrd_req_pre", {31'b0, mem_req_o}, 32'd0);
        tick();
        check("ifrd_req", {31'b0, mem_req_o}, 32'd1);
        check("ifrd_addr", mem_addr_o, 32'h4);
        check("ifrd_we", {31'b0, mem_we_o}, 32'd0);
        check("ifrd_wdat", mem_wdata_o, 32'd0);
        check("ifrd_cnt1", {28'b0, stall_cnt_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ifrd_wait_req", {31'b0, mem_req_o}, 32'd1);
            check("ifrd_wait_addr", mem_addr_o, 32'h4);
            check("ifrd_wait_ack", {31'b0, if_ack_o}, 32'd0);
            check("ifrd_wait_stall", {31'b0, stall_o}, 32'd1);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8C01_0000;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        check("ifrd_ack", {31'b0, if_ack_o}, 32'd1);
        check("ifrd_dack", {31'b0, d_ack_o}, 32'd0);
        check("ifrd_data", if_data_o, 32'h8C01_0000);
        check("ifrd_resp_req", {31'b0, mem_req_o}, 32'd0);
        check("ifrd_resp_stall", {31'b0, stall_o}, 32'd0);
        check("ifrd_cnt5", {28'b0, stall_cnt_o}, 32'd5);
        if_req_i = 1'b0;
        tick();
        check("ifrd_ack_gone", {31'b0, if_ack_o}, 32'd0);
        check("ifrd_data_held", if_data_o, 32'h8C01_0000);
        check("ifrd_cnt_hold", {28'b0, stall_cnt_o}, 32'd5);

        // Stray mem_ack_i in IDLE
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("stray_idle_req", {31'b0, mem_req_o}, 32'd0);
        check("stray_idle_ack", {30'b0, if_ack_o, d_ack_o}, 32'd0);

        // Tie with last grant IF: D first, then IF
        if_req_i = 1'b1; if_addr_i = 32'h0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h10;
        tick();
        check("tie1_d_addr", mem_addr_o, 32'h10);
        check("tie1_d_req", {31'b0, mem_req_o}, 32'd1);
        check("tie1_d_we", {31'b0, mem_we_o}, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        tick();
        mem_ack_i = 1'b0;
        check("tie1_d_ack", {30'b0, if_ack_o, d_ack_o}, 32'd1);
        check("tie1_d_rdata", d_rdata_o, 32'h1111_1111);
        check("tie1_if_data_kept", if_data_o, 32'h8C01_0000);
        check("tie1_stall_if", {31'b0, stall_o}, 32'd1);
        d_req_i = 1'b0;
        tick();
        check("tie1_idle_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        check("tie1_i_addr", mem_addr_o, 32'h0);
        check("tie1_i_req", {31'b0, mem_req_o}, 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h2222_2222;
        tick();
        mem_ack_i = 1'b0;
        check("tie1_i_ack", {30'b0, if_ack_o, d_ack_o}, 32'd2);
        check("tie1_i_data", if_data_o, 32'h2222_2222);
        check("tie1_d_rdata_kept", d_rdata_o, 32'h1111_1111);
        if_req_i = 1'b0;
        tick();

        // D write; port inputs change mid-transaction
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'hDEAD_BEEF;
        tick();
        check("wr_we", {31'b0, mem_we_o}, 32'd1);
        check("wr_addr", mem_addr_o, 32'h20);
        check("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        d_addr_i = 32'h99; d_wdata_i = 32'h0; d_we_i = 1'b0;
        tick();
        check("wr_addr_latched", mem_addr_o, 32'h20);
        check("wr_we_latched", {31'b0, mem_we_o}, 32'd1);
        check("wr_wdata_latched", mem_wdata_o, 32'hDEAD_BEEF);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        tick();
        mem_ack_i = 1'b0;
        check("wr_ack", {30'b0, if_ack_o, d_ack_o}, 32'd1);
        check("wr_rdata_kept", d_rdata_o, 32'h1111_1111);
        d_req_i = 1'b0;
        tick();

        // Tie with last grant D: IF first, then D
        if_req_i = 1'b1; if_addr_i = 32'h40;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h50;
        tick();
        check("tie2_i_addr", mem_addr_o, 32'h40);
        check("tie2_i_we", {31'b0, mem_we_o}, 32'd0);
        check("tie2_i_wdata", mem_wdata_o, 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h3333_3333;
        tick();
        mem_ack_i = 1'b0;
        check("tie2_i_ack", {30'b0, if_ack_o, d_ack_o}, 32'd2);
        check("tie2_i_data", if_data_o, 32'h3333_3333);
        if_req_i = 1'b0;
        tick();
        tick();
        check("tie2_d_addr", mem_addr_o, 32'h50);
        check("tie2_d_req", {31'b0, mem_req_o}, 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h4444_4444;
        tick();
        mem_ack_i = 1'b0;
        check("tie2_d_ack", {30'b0, if_ack_o, d_ack_o}, 32'd1);
        check("tie2_d_rdata", d_rdata_o, 32'h4444_4444);
        d_req_i = 1'b0;
        tick();

        // Reset while in BUS_D, then a stray ack right after release
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h60;
        tick();
        check("rstd_req_before", {31'b0, mem_req_o}, 32'd1);
        #1 rst_i = 1'b0;
        #1;
        check_zero_outputs("rstd");
        tick();
        rst_i = 1'b1;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("rstd_no_ack", {30'b0, if_ack_o, d_ack_o}, 32'd0);
        check("rstd_rearb_req", {31'b0, mem_req_o}, 32'd1);
        check("rstd_rearb_addr", mem_addr_o, 32'h60);
        check("rstd_cnt1", {28'b0, stall_cnt_o}, 32'd1);
        tick();
        check("rstd_wait_ack", {30'b0, if_ack_o, d_ack_o}, 32'd0);
        check("rstd_wait_req", {31'b0, mem_req_o}, 32'd1);
        check("rstd_cnt2", {28'b0, stall_cnt_o}, 32'd2);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h6666_6666;
        tick();
        mem_ack_i = 1'b0;
        check("rstd_done_ack", {30'b0, if_ack_o, d_ack_o}, 32'd1);
        check("rstd_done_rdata", d_rdata_o, 32'h6666_6666);
        d_req_i = 1'b0;
        tick();

        // Counter saturation: IF held, memory never acks
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h80;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat_cnt", {28'b0, stall_cnt_o}, (i > 15) ? 32'd15 : i);
        end
        check("sat_req", {31'b0, mem_req_o}, 32'd1);
        check("sat_stall", {31'b0, stall_o}, 32'd1);
        if_req_i = 1'b0;
        rst_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
